// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Entry layout, default width, NOP encoding and a pointer-width helper.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
    logic                    filled;
  } fq_entry_t;

  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/fq_wrap_ptr.sv
// Wrapping queue index for a power-of-two depth.
// A clear returns the index to entry 0 and takes priority over inc.
module fq_wrap_ptr
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int IW = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;

  // next index: clear to 0, otherwise step and wrap naturally
  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC register and decode.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response straight to decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_pc_stall,
  input  logic            i_flush,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready
);

  localparam int IW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fq_entry_t ent_q [DEPTH];
  fq_entry_t ent_d [DEPTH];
  fq_entry_t head;

  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] unf_q, unf_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [IW-1:0] alloc_idx, fill_idx, pop_idx;

  logic gnt_fire, rv_fill, rv_drop;
  logic byp, vld, pop;

  // request side: registered occupancy gates the request
  always_comb begin
    o_imem_req  = i_reset_n & ~i_flush & (occ_q < FULL);
    o_imem_addr = i_pc;
    gnt_fire    = o_imem_req & i_imem_gnt;
    o_pc_stall  = ~i_flush & ~gnt_fire;
    rv_drop     = i_imem_rvalid & (drop_q != '0);
    rv_fill     = i_imem_rvalid & (drop_q == '0);
  end

  // head presentation, with optional same-cycle forwarding
  always_comb begin
    head = ent_q[pop_idx];
    byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp  = rv_fill & ~head.filled
         & (fill_idx == pop_idx) & (occ_q != '0);
`endif
    vld        = (head.filled | byp) & ~i_flush;
    pop        = vld & i_instr_ready;
    o_instr    = byp ? i_imem_rdata : head.instr;
    o_instr_pc = head.pc;
  end

  assign o_instr_valid = vld;

  // entry updates: allocate, fill, then free the popped head
  always_comb begin
    ent_d = ent_q;
    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].filled = 1'b0;
      end
    end else begin
      if (gnt_fire) begin
        ent_d[alloc_idx].pc     = i_pc;
        ent_d[alloc_idx].filled = 1'b0;
      end
      if (rv_fill && !(byp && pop)) begin
        ent_d[fill_idx].instr  = i_imem_rdata;
        ent_d[fill_idx].filled = 1'b1;
      end
      if (pop) begin
        ent_d[pop_idx].filled = 1'b0;
      end
    end
  end

  // occupancy, unfilled and stale-response counters
  always_comb begin
    occ_d  = occ_q;
    unf_d  = unf_q;
    drop_d = drop_q;
    if (i_flush) begin
      occ_d  = '0;
      unf_d  = '0;
      drop_d = unf_q + drop_q
             - CW'(rv_fill) - CW'(rv_drop);
    end else begin
      occ_d  = occ_q + CW'(gnt_fire) - CW'(pop);
      unf_d  = unf_q + CW'(gnt_fire) - CW'(rv_fill);
      drop_d = drop_q - CW'(rv_drop);
    end
  end

  // state registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      occ_q  <= '0;
      unf_q  <= '0;
      drop_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      occ_q  <= occ_d;
      unf_q  <= unf_d;
      drop_q <= drop_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  fq_wrap_ptr #(.DEPTH(DEPTH)) u_alloc (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .clear (i_flush),
    .inc   (gnt_fire),
    .idx   (alloc_idx)
  );

  fq_wrap_ptr #(.DEPTH(DEPTH)) u_fill (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .clear (i_flush),
    .inc   (rv_fill),
    .idx   (fill_idx)
  );

  fq_wrap_ptr #(.DEPTH(DEPTH)) u_pop (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .clear (i_flush),
    .inc   (pop),
    .idx   (pop_idx)
  );

`ifndef SYNTHESIS
  // a response must always belong to some outstanding request
  a_rsp_owned : assert property (
    @(posedge i_clk) disable iff (!i_reset_n)
    i_imem_rvalid |-> (unf_q != '0 || drop_q != '0)
  );
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue.
// Memory, PC register and expected stream are modelled with queues.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 3;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] i_pc = '0;
  logic            o_pc_stall;
  logic            i_flush = 1'b0;
  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_gnt = 1'b0;
  logic            i_imem_rvalid = 1'b0;
  logic [XLEN-1:0] i_imem_rdata = '0;
  logic            o_instr_valid;
  logic [XLEN-1:0] o_instr;
  logic [XLEN-1:0] o_instr_pc;
  logic            i_instr_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_pc          (i_pc),
    .o_pc_stall    (o_pc_stall),
    .i_flush       (i_flush),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_instr_ready (i_instr_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  exp_t sb[$];
  rsp_t memq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_due = 0;
  int lat_lo = 1, lat_hi = 1;
  int gnt_pct = 100, rdy_pct = 100;
  int grants = 0, deliveries = 0;
  int first_valid_cyc = -1;
  logic        flush_req = 1'b0;
  logic [31:0] flush_tgt = '0;
  logic [31:0] pc_r = '0;
  logic [31:0] first_pc_after_flush = '0;
  bit          await_flush = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_flush = 1'b0;
    i_imem_gnt = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata = '0;
    i_instr_ready = 1'b0;
    i_pc = '0;
    memq.delete();
    sb.delete();
    pc_r = '0;
    last_due = 0;
    flush_req = 1'b0;
    await_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'd0, o_imem_req}, 32'd0);
    check("rst_stall", {31'd0, o_pc_stall}, 32'd1);
    check("rst_valid", {31'd0, o_instr_valid}, 32'd0);
    check("rst_instr", o_instr, 32'd0);
    check("rst_instr_pc", o_instr_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    first_valid_cyc = -1;
    deliveries = 0;
    grants = 0;
  endtask

  task automatic step();
    logic exp_req, exp_stall;
    int due;
    @(posedge clk);
    #1;
    cyc++;
    i_pc = pc_r;
    i_imem_rvalid = 1'b0;
    i_imem_rdata = '0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata = memq[0].data;
      void'(memq.pop_front());
    end
    i_imem_gnt = ($urandom_range(99) < gnt_pct);
    i_instr_ready = ($urandom_range(99) < rdy_pct);
    i_flush = flush_req && (memq.size() <= DEPTH);
    if (i_flush) flush_req = 1'b0;
    #2;
    exp_req = !i_flush && (sb.size() < DEPTH);
    exp_stall = !i_flush && !(exp_req && i_imem_gnt);
    check("imem_req", {31'd0, o_imem_req}, {31'd0, exp_req});
    check("pc_stall", {31'd0, o_pc_stall}, {31'd0, exp_stall});
    if (exp_req) check("imem_addr", o_imem_addr, pc_r);
    if (i_flush) begin
      sb.delete();
      pc_r = flush_tgt;
      await_flush = 1'b1;
    end else if (exp_req && i_imem_gnt) begin
      grants++;
      sb.push_back('{pc: pc_r, instr: pc_r ^ KEY});
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      memq.push_back('{due: due, data: pc_r ^ KEY});
      pc_r = pc_r + 32'd4;
    end
  endtask

  // monitor: every handshake pops the oldest expected instruction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && i_flush) begin
        check("flush_no_valid", {31'd0, o_instr_valid}, 32'd0);
      end
      if (rst_n && o_instr_valid && i_instr_ready) begin
        deliveries++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual_pc=%h required=none",
                   o_instr_pc);
        end else begin
          e = sb.pop_front();
          check("instr_pc", o_instr_pc, e.pc);
          check("instr", o_instr, e.instr);
        end
        if (await_flush) begin
          first_pc_after_flush = o_instr_pc;
          await_flush = 1'b0;
        end
      end
    end
  end

  initial begin
    // steady stream, single-cycle memory
    do_reset();
    lat_lo = 1; lat_hi = 1; gnt_pct = 100; rdy_pct = 100;
    repeat (30) step();
    check("first_latency", first_valid_cyc, EXP_LAT);
    check("stream_rate", {31'd0, deliveries >= 13}, 32'd1);

    // decode stalled: queue fills after DEPTH grants
    do_reset();
    rdy_pct = 0;
    repeat (8) step();
    check("full_grants", grants, DEPTH);
    check("full_req_low", {31'd0, o_imem_req}, 32'd0);
    check("full_stall", {31'd0, o_pc_stall}, 32'd1);
    check("full_no_pop", deliveries, 0);
    rdy_pct = 100;
    repeat (12) step();
    check("resume_grants", {31'd0, grants > DEPTH}, 32'd1);
    check("resume_pops", {31'd0, deliveries >= 4}, 32'd1);

    // memory never grants
    do_reset();
    gnt_pct = 0; rdy_pct = 100;
    repeat (5) begin
      step();
      check("nognt_stall", {31'd0, o_pc_stall}, 32'd1);
      check("nognt_valid", {31'd0, o_instr_valid}, 32'd0);
    end

    // flush with two slow requests in flight
    do_reset();
    lat_lo = 3; lat_hi = 3; gnt_pct = 100; rdy_pct = 100;
    repeat (2) step();
    flush_tgt = 32'h100;
    flush_req = 1'b1;
    repeat (16) step();
    check("flush_first_pc", first_pc_after_flush, 32'h100);
    check("flush_delivered", {31'd0, deliveries > 0}, 32'd1);

    // flush in the middle of a fast stream
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (6) step();
    flush_tgt = 32'h200;
    flush_req = 1'b1;
    repeat (12) step();
    check("flush2_first_pc", first_pc_after_flush, 32'h200);

    // random traffic with random redirects
    do_reset();
    lat_lo = 1; lat_hi = 4; gnt_pct = 70; rdy_pct = 70;
    for (int n = 0; n < 2000; n++) begin
      if (!flush_req && $urandom_range(99) < 3) begin
        flush_tgt = {14'd0, 16'($urandom_range(65535)), 2'b00};
        flush_req = 1'b1;
      end
      step();
    end
    flush_req = 1'b0;
    gnt_pct = 0; rdy_pct = 100;
    repeat (30) step();
    check("drain_sb", sb.size(), 0);
    check("drain_mem", memq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
